// File: rtl/load_cmd_sequencer.sv
// Command-ROM sequencer: fetches load descriptors, holds each on rom_ir until the
// memory controller completes it, and stops on an all-zero word or at the ROM end.
module load_cmd_sequencer #(
    parameter int ROM_AW = 6,
    parameter int IR_W   = 36
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [IR_W-1:0]   rom_data,
    output logic [IR_W-1:0]   rom_ir,
    output logic              cmd_valid,
    input  logic              load_done,
    output logic              busy,
    output logic              eop,
    output logic              err_overflow,
    output logic [ROM_AW:0]   cmd_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        ISSUE,
        RELEASE,
        NEXT,
        DONE
    } state_t;

    localparam logic [ROM_AW-1:0] PTR_LAST  = '1;
    localparam logic [ROM_AW:0]   COUNT_MAX = {1'b1, {ROM_AW{1'b0}}};

    state_t            state;
    state_t            next_state;
    logic [ROM_AW-1:0] ptr;
    logic              resting;

    assign resting = (state == IDLE) || (state == DONE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The descriptor is classified straight off rom_data in CAPTURE so that
    // ISSUE is entered on the third cycle after start.
    always_comb begin
        next_state = state;
        if (abort && !resting) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && !abort) next_state = FETCH;
                end
                FETCH:   next_state = CAPTURE;
                CAPTURE: begin
                    if (rom_data == '0)             next_state = DONE;
                    else if (rom_data[15:0] == '0)  next_state = NEXT;
                    else                            next_state = ISSUE;
                end
                ISSUE: begin
                    if (load_done) next_state = RELEASE;
                end
                RELEASE: begin
                    if (!load_done) next_state = NEXT;
                end
                NEXT: begin
                    if (ptr == PTR_LAST) next_state = DONE;
                    else                 next_state = FETCH;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        rom_en    = (state == FETCH);
        rom_addr  = ptr;
        cmd_valid = (state == ISSUE);
        busy      = !resting;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr          <= '0;
            rom_ir       <= '0;
            eop          <= 1'b0;
            err_overflow <= 1'b0;
            cmd_count    <= '0;
        end else begin
            if (resting && next_state == FETCH) begin
                ptr          <= '0;
                cmd_count    <= '0;
                eop          <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (state == CAPTURE && next_state == ISSUE) begin
                rom_ir <= rom_data;
            end
            if (state == CAPTURE && next_state == DONE) begin
                eop <= 1'b1;
            end
            if (state == NEXT && next_state != IDLE) begin
                if (cmd_count != COUNT_MAX) cmd_count <= cmd_count + 1'b1;
                if (next_state == DONE) err_overflow <= 1'b1;
                else                    ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_cmd_sequencer.sv
// Directed bench for load_cmd_sequencer: a synchronous ROM model, a load_done
// responder and a queue of expected descriptors checked at each issue.
module tb_load_cmd_sequencer;

    localparam int ROM_AW = 6;
    localparam int IR_W   = 36;

    localparam logic [IR_W-1:0] DESC_A    = 36'h5_0100_0040;
    localparam logic [IR_W-1:0] DESC_B    = 36'h7_0200_0020;
    localparam logic [IR_W-1:0] DESC_C    = 36'h4_0300_0010;
    localparam logic [IR_W-1:0] DESC_SKIP = 36'hF_1234_0000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [IR_W-1:0]   rom_data = '0;
    logic [IR_W-1:0]   rom_ir;
    logic              cmd_valid;
    logic              load_done = 1'b0;
    logic              busy;
    logic              eop;
    logic              err_overflow;
    logic [ROM_AW:0]   cmd_count;

    logic [IR_W-1:0]   rom [2**ROM_AW];
    logic [IR_W-1:0]   exp_q [$];

    int checks = 0;
    int errors = 0;

    logic watch_wrap = 1'b0;
    logic seen_fetch = 1'b0;
    logic wrapped    = 1'b0;

    load_cmd_sequencer #(.ROM_AW(ROM_AW), .IR_W(IR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .rom_en       (rom_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rom_ir       (rom_ir),
        .cmd_valid    (cmd_valid),
        .load_done    (load_done),
        .busy         (busy),
        .eop          (eop),
        .err_overflow (err_overflow),
        .cmd_count    (cmd_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    always @(negedge clock) begin
        if (watch_wrap && rom_en) begin
            if (seen_fetch && rom_addr == '0) wrapped = 1'b1;
            seen_fetch = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2**ROM_AW; i++) rom[i] = '0;
    endtask

    task automatic load_ab();
        clear_rom();
        rom[0] = DESC_A;
        rom[1] = DESC_B;
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        logic [IR_W-1:0] exp;
        while (!cmd_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_issue"}, cmd_valid, 1);
        if (cmd_valid) begin
            chk({tag, "_queued"}, exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                chk({tag, "_ir"}, rom_ir, exp);
            end
        end
    endtask

    task automatic serve(input string tag, input int hold);
        logic [ROM_AW:0] cnt;
        wait_issue(tag);
        if (!cmd_valid) return;
        tick();
        tick();
        chk({tag, "_held"}, cmd_valid, 1);
        load_done = 1'b1;
        tick();
        chk({tag, "_release"}, cmd_valid, 0);
        cnt = cmd_count;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_rel_valid"}, cmd_valid, 0);
            chk({tag, "_rel_fetch"}, rom_en, 0);
            chk({tag, "_rel_count"}, cmd_count, cnt);
        end
        load_done = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        clear_rom();
        repeat (3) tick();
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_ir", rom_ir, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eop", eop, 0);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_count", cmd_count, 0);
        reset = 1'b1;
        tick();

        // Two descriptors then terminator; second release held for 5 cycles.
        load_ab();
        exp_q.push_back(DESC_A);
        exp_q.push_back(DESC_B);
        pulse_start();
        chk("a_fetch_en", rom_en, 1);
        chk("a_fetch_addr", rom_addr, 0);
        chk("a_busy", busy, 1);
        tick();
        chk("a_lat2", cmd_valid, 0);
        tick();
        chk("a_lat3", cmd_valid, 1);
        serve("a0", 0);
        serve("a1", 5);
        wait_idle("a");
        chk("a_eop", eop, 1);
        chk("a_ovf", err_overflow, 0);
        chk("a_count", cmd_count, 2);
        chk("a_q_empty", exp_q.size(), 0);

        // Zero-size word is skipped but counted.
        clear_rom();
        rom[0] = DESC_SKIP;
        rom[1] = DESC_C;
        exp_q.push_back(DESC_C);
        pulse_start();
        serve("s", 0);
        wait_idle("s");
        chk("s_eop", eop, 1);
        chk("s_count", cmd_count, 2);
        chk("s_q_empty", exp_q.size(), 0);

        // Full ROM with no terminator: stops at the end without wrapping.
        for (int i = 0; i < 2**ROM_AW; i++) begin
            rom[i] = {4'h3, 16'(i * 4), 16'(i + 1)};
            exp_q.push_back(rom[i]);
        end
        seen_fetch = 1'b0;
        wrapped    = 1'b0;
        watch_wrap = 1'b1;
        pulse_start();
        for (int i = 0; i < 2**ROM_AW; i++) serve("o", 0);
        wait_idle("o");
        watch_wrap = 1'b0;
        chk("o_ovf", err_overflow, 1);
        chk("o_eop", eop, 0);
        chk("o_count", cmd_count, 64);
        chk("o_no_wrap", wrapped, 0);
        chk("o_q_empty", exp_q.size(), 0);

        // Abort mid-issue, abort beats start, then a clean restart from address 0.
        load_ab();
        exp_q.push_back(DESC_A);
        pulse_start();
        wait_issue("ab");
        abort = 1'b1;
        tick();
        chk("ab_valid", cmd_valid, 0);
        chk("ab_busy", busy, 0);
        chk("ab_count", cmd_count, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_prio", busy, 0);
        abort = 1'b0;
        exp_q.push_back(DESC_A);
        exp_q.push_back(DESC_B);
        pulse_start();
        chk("ab_re_en", rom_en, 1);
        chk("ab_re_addr", rom_addr, 0);
        serve("ab0", 0);
        serve("ab1", 0);
        wait_idle("ab");
        chk("ab_eop", eop, 1);
        chk("ab_done_count", cmd_count, 2);

        // Reset pulse during ISSUE.
        exp_q.push_back(DESC_A);
        pulse_start();
        wait_issue("r");
        reset = 1'b0;
        tick();
        chk("r_rom_en", rom_en, 0);
        chk("r_rom_addr", rom_addr, 0);
        chk("r_rom_ir", rom_ir, 0);
        chk("r_valid", cmd_valid, 0);
        chk("r_busy", busy, 0);
        chk("r_eop", eop, 0);
        chk("r_ovf", err_overflow, 0);
        chk("r_count", cmd_count, 0);
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
